// File: rtl/l2_sched_pkg.sv
// Shared types and helpers for the L2 request scheduler.
//   grant_e   : which requester owns the L2 port
//   state_e   : scheduler FSM states
//   same_line : line-granular address compare (ignores the byte offset)
package l2_sched_pkg;

  localparam int LINE_OFFSET = 5;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_D,
    GNT_I,
    GNT_P
  } grant_e;

  typedef enum logic [1:0] {
    IDLE,
    GRANT_D,
    GRANT_I,
    GRANT_P
  } state_e;

  // Callers zero-extend their addresses to 64 bits so one helper serves any ADDR_W.
  function automatic logic same_line(input logic [63:0] a, input logic [63:0] b);
    return (a >> LINE_OFFSET) == (b >> LINE_OFFSET);
  endfunction

endpackage

// File: rtl/l2_sched_prio.sv
// Combinational winner selection for the L2 request scheduler.
//   d_req        : dcache read or write pending
//   i_read/p_read: icache / prefetch read pending
//   starve_cnt   : dcache grants taken while icache was waiting
//   i/p_address  : line addresses used for the merge compare
//   winner       : requester that takes the next grant
//   merge        : icache grant also satisfies the prefetch (same line)
module l2_sched_prio import l2_sched_pkg::*; #(
  parameter int ADDR_W       = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic              d_req,
  input  logic              i_read,
  input  logic              p_read,
  input  logic [CNT_W-1:0]  starve_cnt,
  input  logic [ADDR_W-1:0] i_address,
  input  logic [ADDR_W-1:0] p_address,
  output grant_e            winner,
  output logic              merge
);

  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

  always_comb begin
    winner = GNT_NONE;
    // A starved icache outranks the dcache; otherwise plain fixed priority.
    if (i_read && (starve_cnt == LIMIT_C)) winner = GNT_I;
    else if (d_req)                         winner = GNT_D;
    else if (i_read)                        winner = GNT_I;
    else if (p_read)                        winner = GNT_P;
    // A prefetch for the line icache is about to fetch rides along for free.
    merge = (winner == GNT_I) && p_read &&
            same_line(64'(i_address), 64'(p_address));
  end

endmodule

// File: rtl/l2_req_scheduler.sv
// Arbitrates the single L2 request port between dcache, icache and prefetcher.
//   d_*  : dcache line read/writeback request, d_resp completion pulse
//   i_*  : icache line read request, i_resp completion pulse
//   p_*  : prefetch line read request, p_resp completion pulse
//   rdata: l2_rdata broadcast, meaningful only alongside a *_resp
//   l2_* : registered request to l2_cache; l2_resp/l2_rdata come back
// One transaction is outstanding at a time; every completion returns to IDLE
// for one cycle before the next grant is taken.
module l2_req_scheduler #(
  parameter int STARVE_LIMIT = 4,
  parameter int LINE_W       = 256,
  parameter int ADDR_W       = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic              d_resp,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic              i_resp,
  input  logic              p_read,
  input  logic [ADDR_W-1:0] p_address,
  output logic              p_resp,
  output logic [LINE_W-1:0] rdata,
  output logic              l2_read,
  output logic              l2_write,
  output logic [ADDR_W-1:0] l2_address,
  output logic [LINE_W-1:0] l2_wdata,
  input  logic              l2_resp,
  input  logic [LINE_W-1:0] l2_rdata
);

  import l2_sched_pkg::*;

  localparam int               CNT_W   = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

  typedef struct packed {
    logic              rd;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] wdata;
  } l2_req_t;

  state_e           state_q, state_d;
  logic             merge_q, merge_d;
  logic [CNT_W-1:0] starve_q, starve_d;
  l2_req_t          req_q, req_d;

  grant_e           winner;
  logic             merge_hit;

  l2_sched_prio #(
    .ADDR_W      (ADDR_W),
    .STARVE_LIMIT(STARVE_LIMIT),
    .CNT_W       (CNT_W)
  ) u_prio (
    .d_req     (d_read | d_write),
    .i_read    (i_read),
    .p_read    (p_read),
    .starve_cnt(starve_q),
    .i_address (i_address),
    .p_address (p_address),
    .winner    (winner),
    .merge     (merge_hit)
  );

  always_comb begin
    state_d  = state_q;
    merge_d  = merge_q;
    starve_d = starve_q;
    req_d    = req_q;
    case (state_q)
      IDLE: begin
        if (winner != GNT_NONE) begin
          merge_d = merge_hit;
          case (winner)
            GNT_D: begin
              state_d     = GRANT_D;
              req_d.rd    = d_read;
              req_d.wr    = d_write;
              req_d.addr  = d_address;
              req_d.wdata = d_write ? d_wdata : '0;
            end
            GNT_I: begin
              state_d     = GRANT_I;
              req_d.rd    = 1'b1;
              req_d.wr    = 1'b0;
              req_d.addr  = i_address;
              req_d.wdata = '0;
            end
            GNT_P: begin
              state_d     = GRANT_P;
              req_d.rd    = 1'b1;
              req_d.wr    = 1'b0;
              req_d.addr  = p_address;
              req_d.wdata = '0;
            end
            default: ;
          endcase
          // Count dcache wins that left icache waiting; any icache win resets it.
          if ((winner == GNT_D) && i_read)
            starve_d = (starve_q == LIMIT_C) ? starve_q : starve_q + CNT_W'(1);
          else if (winner == GNT_I)
            starve_d = '0;
        end
      end
      GRANT_D, GRANT_I, GRANT_P: begin
        if (l2_resp) begin
          state_d  = IDLE;
          req_d.rd = 1'b0;
          req_d.wr = 1'b0;
          merge_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      merge_q  <= 1'b0;
      starve_q <= '0;
      req_q    <= '0;
    end else begin
      state_q  <= state_d;
      merge_q  <= merge_d;
      starve_q <= starve_d;
      req_q    <= req_d;
    end
  end

  assign l2_read    = req_q.rd;
  assign l2_write   = req_q.wr;
  assign l2_address = req_q.addr;
  assign l2_wdata   = req_q.wdata;

  // Completions are combinational on l2_resp; IDLE never responds, so a
  // response left over from an abandoned transaction is dropped.
  assign d_resp = l2_resp && (state_q == GRANT_D);
  assign i_resp = l2_resp && (state_q == GRANT_I);
  assign p_resp = l2_resp && ((state_q == GRANT_P) || ((state_q == GRANT_I) && merge_q));
  assign rdata  = l2_rdata;

endmodule

// File: tb/tb_l2_req_scheduler.sv
module tb_l2_req_scheduler;

  localparam int LIMIT = 4;

  logic         clk, reset_n;
  logic         d_read, d_write, i_read, p_read;
  logic [31:0]  d_address, i_address, p_address;
  logic [255:0] d_wdata, rdata, l2_wdata, l2_rdata;
  logic         d_resp, i_resp, p_resp;
  logic         l2_read, l2_write, l2_resp;
  logic [31:0]  l2_address;

  l2_req_scheduler #(.STARVE_LIMIT(LIMIT), .LINE_W(256), .ADDR_W(32)) dut (
    .clk(clk), .reset_n(reset_n),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata), .d_resp(d_resp),
    .i_read(i_read), .i_address(i_address), .i_resp(i_resp),
    .p_read(p_read), .p_address(p_address), .p_resp(p_resp),
    .rdata(rdata),
    .l2_read(l2_read), .l2_write(l2_write), .l2_address(l2_address), .l2_wdata(l2_wdata),
    .l2_resp(l2_resp), .l2_rdata(l2_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [31:0]  addr;
    logic         wr;
    logic [255:0] data;
  } req_t;

  typedef struct {
    int           start;
    int           fin;
    logic [31:0]  addr;
    logic         wr;
    logic [255:0] wdata;
    logic [2:0]   mask;   // {d,i,p} responses seen at completion
    logic [255:0] rdata;
    logic [255:0] l2d;
  } txn_t;

  int checks = 0, failures = 0, cyc = 0, stray = 0;

  // requester side
  req_t dq[$], iq[$], pq[$];
  req_t d_cur, i_cur, p_cur;
  logic d_act, i_act, p_act;
  int   d_act_cyc;
  logic [2:0] seen;

  // L2 responder
  logic rbusy, stale_req;
  int   rcnt, lat_fixed;

  // reference model: one outstanding transaction or none
  logic         m_busy, m_merge, m_wr;
  int           m_who, m_starve;
  logic [31:0]  m_addr;
  logic [255:0] m_wdata;

  // observed transactions on the L2 side
  txn_t log_q[$];
  txn_t cur;
  logic open;

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = 32'h1000 + (32'($urandom_range(0, 15)) << 5);
    a[4:0] = 5'($urandom);
    return a;
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_d(input logic [31:0] a, input logic w, input logic [255:0] dat);
    req_t r;
    r.addr = a; r.wr = w; r.data = dat;
    dq.push_back(r);
  endtask

  task automatic push_i(input logic [31:0] a);
    req_t r;
    r.addr = a; r.wr = 1'b0; r.data = '0;
    iq.push_back(r);
  endtask

  task automatic push_p(input logic [31:0] a);
    req_t r;
    r.addr = a; r.wr = 1'b0; r.data = '0;
    pq.push_back(r);
  endtask

  // One clock: check and advance the model at negedge, then drive
  // requesters and the L2 responder just after the following posedge.
  task automatic tick();
    logic [2:0] rsp, emask;
    int who;
    @(negedge clk);
    cyc++;
    rsp = {d_resp, i_resp, p_resp};

    emask = 3'b000;
    if (m_busy && l2_resp) begin
      if (m_who == 0)      emask = 3'b100;
      else if (m_who == 1) emask = m_merge ? 3'b011 : 3'b010;
      else                 emask = 3'b001;
    end
    chk("strobes", 256'({l2_read, l2_write}), m_busy ? 256'({!m_wr, m_wr}) : 256'(0));
    chk("resp", 256'(rsp), 256'(emask));
    chk("rdata", rdata, l2_rdata);
    if (m_busy) begin
      chk("l2_address", 256'(l2_address), 256'(m_addr));
      chk("l2_wdata", l2_wdata, m_wr ? m_wdata : 256'(0));
    end

    if (!reset_n) open = 1'b0;
    else begin
      if ((l2_read || l2_write) && !open) begin
        open = 1'b1;
        cur.start = cyc; cur.addr = l2_address; cur.wr = l2_write; cur.wdata = l2_wdata;
      end
      if (rsp != 3'b000) begin
        if (open) begin
          cur.fin = cyc; cur.mask = rsp; cur.rdata = rdata; cur.l2d = l2_rdata;
          log_q.push_back(cur);
          open = 1'b0;
        end else stray++;
      end
    end

    if (!reset_n) begin
      m_busy = 1'b0; m_merge = 1'b0; m_starve = 0;
    end else if (m_busy) begin
      if (l2_resp) begin m_busy = 1'b0; m_merge = 1'b0; end
    end else begin
      who = -1;
      if (i_read && m_starve == LIMIT) who = 1;
      else if (d_read || d_write)      who = 0;
      else if (i_read)                 who = 1;
      else if (p_read)                 who = 2;
      if (who >= 0) begin
        m_busy = 1'b1;
        m_who = who;
        m_merge = (who == 1) && p_read && (i_address[31:5] == p_address[31:5]);
        if (who == 0) begin m_addr = d_address; m_wr = d_write; m_wdata = d_wdata; end
        else if (who == 1) begin m_addr = i_address; m_wr = 1'b0; m_wdata = '0; end
        else begin m_addr = p_address; m_wr = 1'b0; m_wdata = '0; end
        if (who == 0 && i_read) m_starve = (m_starve < LIMIT) ? m_starve + 1 : LIMIT;
        else if (who == 1)      m_starve = 0;
      end
    end
    seen = rsp;

    @(posedge clk);
    #1;
    if (!reset_n) begin
      d_act = 1'b0; i_act = 1'b0; p_act = 1'b0;
    end else begin
      if (seen[2]) d_act = 1'b0;
      if (seen[1]) i_act = 1'b0;
      if (seen[0]) p_act = 1'b0;
      if (!d_act && dq.size() > 0) begin d_cur = dq.pop_front(); d_act = 1'b1; d_act_cyc = cyc + 1; end
      if (!i_act && iq.size() > 0) begin i_cur = iq.pop_front(); i_act = 1'b1; end
      if (!p_act && pq.size() > 0) begin p_cur = pq.pop_front(); p_act = 1'b1; end
    end
    d_read = d_act && !d_cur.wr; d_write = d_act && d_cur.wr;
    d_address = d_cur.addr; d_wdata = d_cur.data;
    i_read = i_act; i_address = i_cur.addr;
    p_read = p_act; p_address = p_cur.addr;

    l2_rdata = rand256();
    l2_resp = 1'b0;
    if (!reset_n) rbusy = 1'b0;
    else if (stale_req) begin l2_resp = 1'b1; stale_req = 1'b0; end
    else begin
      if ((l2_read || l2_write) && !rbusy) begin
        rbusy = 1'b1;
        rcnt = (lat_fixed >= 0) ? lat_fixed : int'($urandom_range(0, 3));
      end
      if (rbusy) begin
        if (rcnt == 0) begin l2_resp = 1'b1; rbusy = 1'b0; end
        else rcnt--;
      end
    end
  endtask

  task automatic wait_txns(input int n, input int budget, input string name);
    int k;
    k = 0;
    while (log_q.size() < n && k < budget) begin tick(); k++; end
    checks++;
    if (log_q.size() < n) begin
      failures++;
      $display("FAIL %s timeout: transactions=%0d required=%0d", name, log_q.size(), n);
    end
    repeat (2) tick();
  endtask

  function automatic logic all_idle();
    return dq.size() == 0 && iq.size() == 0 && pq.size() == 0 &&
           !d_act && !i_act && !p_act && !m_busy;
  endfunction

  initial begin
    txn_t t;
    int base, k;
    logic [255:0] dw1;
    reset_n = 1'b0;
    d_read = 0; d_write = 0; i_read = 0; p_read = 0;
    d_address = '0; i_address = '0; p_address = '0; d_wdata = '0;
    l2_resp = 0; l2_rdata = '0;
    d_cur = '{addr: 32'h0, wr: 1'b0, data: 256'h0};
    i_cur = d_cur; p_cur = d_cur;
    d_act = 0; i_act = 0; p_act = 0; d_act_cyc = 0; seen = '0;
    rbusy = 0; stale_req = 0; rcnt = 0; lat_fixed = -1;
    m_busy = 0; m_merge = 0; m_wr = 0; m_who = 0; m_starve = 0; m_addr = '0; m_wdata = '0;
    open = 0;

    repeat (3) tick();
    chk("rst_strobes", 256'({l2_read, l2_write}), 256'(0));
    chk("rst_resps", 256'({d_resp, i_resp, p_resp}), 256'(0));
    chk("rst_addr", 256'(l2_address), 256'(0));
    chk("rst_wdata", l2_wdata, 256'(0));
    reset_n = 1'b1;
    tick();

    // solo dcache writeback, fixed 3-cycle L2 latency
    lat_fixed = 3;
    dw1 = {8{32'hA5C3_0F96}};
    base = log_q.size();
    push_d(32'h0000_1040, 1'b1, dw1);
    wait_txns(base + 1, 30, "t1");
    if (log_q.size() > base) begin
      t = log_q[base];
      chk("t1_start", 256'(t.start), 256'(d_act_cyc + 1));
      chk("t1_latency", 256'(t.fin - t.start), 256'(3));
      chk("t1_mask", 256'(t.mask), 256'(3'b100));
      chk("t1_wr", 256'(t.wr), 256'(1));
      chk("t1_addr", 256'(t.addr), 256'(32'h1040));
      chk("t1_wdata", t.wdata, dw1);
    end
    lat_fixed = -1;

    // solo icache and solo prefetch
    base = log_q.size();
    push_i(32'h60);
    wait_txns(base + 1, 30, "t2");
    if (log_q.size() > base) begin
      t = log_q[base];
      chk("t2_mask", 256'(t.mask), 256'(3'b010));
      chk("t2_addr", 256'(t.addr), 256'(32'h60));
      chk("t2_wdata", t.wdata, 256'(0));
      chk("t2_rdata", t.rdata, t.l2d);
    end
    base = log_q.size();
    push_p(32'hA0);
    wait_txns(base + 1, 30, "t3");
    if (log_q.size() > base) begin
      chk("t3_mask", 256'(log_q[base].mask), 256'(3'b001));
      chk("t3_addr", 256'(log_q[base].addr), 256'(32'hA0));
    end

    // all three at once: D, I, P with one idle cycle between
    base = log_q.size();
    push_d(32'h100, 1'b0, '0); push_i(32'h200); push_p(32'h300);
    wait_txns(base + 3, 60, "t4");
    if (log_q.size() >= base + 3) begin
      chk("t4_mask0", 256'(log_q[base].mask), 256'(3'b100));
      chk("t4_mask1", 256'(log_q[base+1].mask), 256'(3'b010));
      chk("t4_mask2", 256'(log_q[base+2].mask), 256'(3'b001));
      chk("t4_addr0", 256'(log_q[base].addr), 256'(32'h100));
      chk("t4_addr1", 256'(log_q[base+1].addr), 256'(32'h200));
      chk("t4_addr2", 256'(log_q[base+2].addr), 256'(32'h300));
      chk("t4_gap0", 256'(log_q[base+1].start - log_q[base].fin), 256'(2));
      chk("t4_gap1", 256'(log_q[base+2].start - log_q[base+1].fin), 256'(2));
    end

    // starvation: dcache streams reads while icache waits
    base = log_q.size();
    for (int j = 0; j < 6; j++) push_d(32'h4000 + 32'(j) * 32'h40, 1'b0, '0);
    push_i(32'h2000);
    wait_txns(base + 7, 120, "t5");
    if (log_q.size() >= base + 7) begin
      for (int j = 0; j < 7; j++)
        chk($sformatf("t5_mask%0d", j), 256'(log_q[base+j].mask), (j == 4) ? 256'(3'b010) : 256'(3'b100));
      chk("t5_iaddr", 256'(log_q[base+4].addr), 256'(32'h2000));
    end
    chk("t5_starve_cnt", 256'(dut.starve_q), 256'(0));

    // merge: same line -> one L2 read serving both
    base = log_q.size();
    push_i(32'h0000_0480); push_p(32'h0000_049C);
    wait_txns(base + 1, 30, "t6");
    repeat (4) tick();
    chk("t6_count", 256'(log_q.size()), 256'(base + 1));
    if (log_q.size() > base) begin
      chk("t6_mask", 256'(log_q[base].mask), 256'(3'b011));
      chk("t6_addr", 256'(log_q[base].addr), 256'(32'h480));
    end

    // different lines -> two reads, icache first
    base = log_q.size();
    push_i(32'h480); push_p(32'h4A0);
    wait_txns(base + 2, 40, "t7");
    if (log_q.size() >= base + 2) begin
      chk("t7_mask0", 256'(log_q[base].mask), 256'(3'b010));
      chk("t7_addr0", 256'(log_q[base].addr), 256'(32'h480));
      chk("t7_mask1", 256'(log_q[base+1].mask), 256'(3'b001));
      chk("t7_addr1", 256'(log_q[base+1].addr), 256'(32'h4A0));
    end

    // reset in the middle of a dcache grant, then a stale l2_resp
    lat_fixed = 6;
    base = log_q.size();
    push_d(32'h700, 1'b0, '0);
    k = 0;
    while (!l2_read && k < 10) begin tick(); k++; end
    chk("t8_granted", 256'(l2_read), 256'(1));
    reset_n = 1'b0;
    stale_req = 1'b1;
    tick();
    reset_n = 1'b1;
    tick();
    #1;
    chk("t8_stale_l2_resp", 256'(l2_resp), 256'(1));
    chk("t8_strobes", 256'({l2_read, l2_write}), 256'(0));
    chk("t8_addr", 256'(l2_address), 256'(0));
    chk("t8_wdata", l2_wdata, 256'(0));
    chk("t8_resps", 256'({d_resp, i_resp, p_resp}), 256'(0));
    lat_fixed = -1;
    repeat (3) tick();
    chk("t8_no_txn", 256'(log_q.size()), 256'(base));
    push_d(32'h740, 1'b0, '0);
    wait_txns(base + 1, 30, "t8_after");
    if (log_q.size() > base) begin
      chk("t8_mask", 256'(log_q[base].mask), 256'(3'b100));
      chk("t8_addr2", 256'(log_q[base].addr), 256'(32'h740));
    end

    // randomized traffic against the model
    for (int c = 0; c < 1500; c++) begin
      if (dq.size() == 0 && !d_act && $urandom_range(0, 2) == 0)
        push_d(rand_addr(), 1'($urandom), rand256());
      if (iq.size() == 0 && !i_act && $urandom_range(0, 2) == 0)
        push_i(rand_addr());
      if (pq.size() == 0 && !p_act && $urandom_range(0, 2) == 0)
        push_p(rand_addr());
      tick();
    end
    k = 0;
    while (!all_idle() && k < 300) begin tick(); k++; end
    chk("drain", 256'(all_idle()), 256'(1));
    chk("stray_resp", 256'(stray), 256'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/l2_req_scheduler.md
Name: l2_req_scheduler

Overview:
Shares the single L2 cache request port between the data cache, instruction cache and instruction prefetcher, at 256-bit line granularity. Fixed priority is dcache > icache > prefetch, with a starvation counter that promotes a waiting icache, and a merge path that serves an icache miss and a prefetch to the same line with one L2 access. It sits between the three line-side requesters and l2_cache.

Parameters:
STARVE_LIMIT, 4, consecutive dcache grants while icache waits before icache is forced to win
LINE_W, 256, cacheline width in bits
ADDR_W, 32, address width; line-aligned addresses only (low 5 bits ignored in compares)

Ports:
clk  in  1  clock
reset_n  in  1  synchronous active-low reset
d_read  in  1  dcache line read request
d_write  in  1  dcache line write request (writeback)
d_address  in  ADDR_W  dcache line address
d_wdata  in  LINE_W  dcache writeback data
d_resp  out  1  dcache completion pulse
i_read  in  1  icache line read request
i_address  in  ADDR_W  icache line address
i_resp  out  1  icache completion pulse
p_read  in  1  prefetcher line read request
p_address  in  ADDR_W  prefetch line address
p_resp  out  1  prefetch completion pulse
rdata  out  LINE_W  read data, broadcast to all requesters, valid with any *_resp
l2_read  out  1  L2 read request
l2_write  out  1  L2 write request
l2_address  out  ADDR_W  L2 address
l2_wdata  out  LINE_W  L2 write data
l2_resp  in  1  L2 completion
l2_rdata  in  LINE_W  L2 read data

Behaviour:
- Reset (reset_n=0 at posedge): state IDLE, grant NONE, starve_cnt=0, merge=0. l2_read, l2_write, d_resp, i_resp and p_resp are all 0. l2_address and l2_wdata are 0. Reset mid-transaction abandons it; any l2_resp received while in IDLE is ignored.
- Requester contract: a request is held stable until the cycle of its *_resp and is dropped in the following cycle. d_read and d_write are never both set.
- FSM states: IDLE, GRANT_D, GRANT_I, GRANT_P.
- IDLE, cycle N, with requests pending: the winner is chosen as follows.
  - icache if i_read and starve_cnt==STARVE_LIMIT.
  - Otherwise dcache if d_read|d_write.
  - Otherwise icache if i_read.
  - Otherwise prefetch if p_read.
  - Winner's address, data and direction are registered. Cycle N+1: state is GRANT_x and the l2_* outputs are driven from those registers.
- Merge: at the grant edge, if i_read, p_read and i_address[31:5]==p_address[31:5], set merge=1 and grant as GRANT_I. Merging applies whether icache wins by priority or by starvation, but never when dcache wins.
- GRANT_x: l2_read/l2_write stay asserted until l2_resp.
  - In the l2_resp cycle, x_resp=1 combinationally and rdata=l2_rdata; in GRANT_I with merge=1, p_resp=1 in the same cycle.
  - Next cycle: state IDLE, all l2_* request strobes low, merge cleared.
  - Minimum gap between L2 transactions is 1 IDLE cycle.
- *_resp is exactly one cycle wide and never asserted outside a GRANT state.
- rdata passes l2_rdata through in every cycle. It is meaningful only with a resp, and no rdata register is kept.
- starve_cnt is updated at each grant edge:
  - dcache wins while i_read is high: increment, saturating at STARVE_LIMIT.
  - icache wins: clear to 0.
  - Otherwise: hold.
- Prefetch is granted only when neither dcache nor icache is requesting. A pending prefetch is never preempted once granted.
- Write grants drive l2_wdata=d_wdata as latched; l2_wdata=0 for reads.

Decomposition:
- A shared package l2_sched_pkg holds:
  - the grant enum (NONE, D, I, P);
  - the LINE_OFFSET=5 constant;
  - the line-address compare helper function.
- One natural sub-module, l2_sched_prio, is combinational: it takes requests, starve_cnt and addresses and returns the winner and merge flag.
- The FSM, latches and counter stay in the top module.

Test Plan:
- Solo requests:
  - d_write at 0x0000_1040, l2_resp 3 cycles later: l2_write and l2_wdata seen one cycle after the request; d_resp is one pulse; i_resp and p_resp stay 0.
  - i_read at 0x60: i_resp pulses with rdata equal to l2_rdata.
  - p_read alone: p_resp pulses.
- Simultaneous d_read(0x100), i_read(0x200), p_read(0x300):
  - Order is D, then I, then P.
  - Exactly one IDLE cycle separates consecutive transactions.
- Starvation, STARVE_LIMIT=4: dcache re-requests back-to-back while i_read is held.
  - Four dcache grants complete.
  - The fifth grant is icache even though d_read is high.
  - starve_cnt returns to 0 afterwards.
- Merge: i_read=0x0000_0480 and p_read=0x0000_049C together.
  - A single L2 read at 0x480.
  - i_resp and p_resp pulse in the same cycle.
  - Exactly one l2_read transaction is observed.
- Non-merge: i_read=0x480 and p_read=0x4A0.
  - Two separate L2 reads, icache first.
  - Each resp is a distinct single pulse.
- Reset mid-transaction: reset_n=0 for 1 cycle while in GRANT_D, then l2_resp arrives.
  - All outputs are 0 after reset.
  - The stale l2_resp produces no *_resp.
  - The next d_read is served normally.
